// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage LEGv8 pipeline: stall/flush enables and registered EX forwarding selects.
// Statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic             id_usesRn,
  input  logic             id_usesRm,
  input  logic [4:0]       ex_Rd,
  input  logic             ex_RegWrite,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_Rd,
  input  logic             mem_RegWrite,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_BUBBLE,
    ACT_FLUSH,
    ACT_FREEZE
  } act_e;

  localparam logic [4:0] XZR = 5'd31;

  act_e       act;
  logic       ex_fwd_ok;
  logic       mem_fwd_ok;
  logic       lu;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] fwd_a_d, fwd_a_q;
  logic [1:0] fwd_b_d, fwd_b_q;

  // EX producer is preferred: it holds the youngest value of the register.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [4:0] src,
    input logic       ex_ok,
    input logic [4:0] ex_rd,
    input logic       mem_ok,
    input logic [4:0] mem_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses) begin
      if (ex_ok && (ex_rd == src)) begin
        sel = 2'b01;
      end else if (mem_ok && (mem_rd == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ex_fwd_ok  = ex_RegWrite && (ex_Rd != XZR);
    mem_fwd_ok = mem_RegWrite && (mem_Rd != XZR);
    lu = ex_MemRead && ex_fwd_ok &&
         ((id_usesRn && (id_Rn == ex_Rd)) || (id_usesRm && (id_Rm == ex_Rd)));
    sel_a = fwd_sel(id_usesRn, id_Rn, ex_fwd_ok, ex_Rd, mem_fwd_ok, mem_Rd);
    sel_b = fwd_sel(id_usesRm, id_Rm, ex_fwd_ok, ex_Rd, mem_fwd_ok, mem_Rd);
  end

  always_comb begin
    if (ext_stall) begin
      act = ACT_FREEZE;
    end else if (branch_taken) begin
      act = ACT_FLUSH;
    end else if (lu) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_RUN;
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a_d    = sel_a;
    fwd_b_d    = sel_b;
    unique case (act)
      ACT_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
      end
      ACT_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        fwd_a_d    = 2'b00;
        fwd_b_d    = 2'b00;
      end
      ACT_BUBBLE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        fwd_a_d    = 2'b00;
        fwd_b_d    = 2'b00;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwdA = fwd_a_q;
  assign fwdB = fwd_b_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             stall_inc;
  logic             flush_inc;

  always_comb begin
    stall_inc   = (act == ACT_FREEZE) || (act == ACT_BUBBLE);
    flush_inc   = (act == ACT_FLUSH);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table with a scoreboard for the registered outputs.
module tb_hazard_ctrl;

  localparam int unsigned TW = 4;
  localparam int unsigned CMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_Rn, id_Rm, ex_Rd, mem_Rd;
  logic          id_usesRn, id_usesRm, ex_RegWrite, ex_MemRead, mem_RegWrite;
  logic          branch_taken, ext_stall;
  logic          pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]    fwdA, fwdB;
  logic [TW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_usesRn(id_usesRn), .id_usesRm(id_usesRm),
    .ex_Rd(ex_Rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .mem_Rd(mem_Rd), .mem_RegWrite(mem_RegWrite),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_flush}
  typedef struct {
    string      name;
    logic [4:0] rn;  logic [4:0] rm;  logic urn;  logic urm;
    logic [4:0] exrd; logic exrw; logic exmr;
    logic [4:0] memrd; logic memrw;
    logic       br;  logic es;
    logic [3:0] ctl; logic [1:0] fa; logic [1:0] fb;
    int unsigned ds; int unsigned df;
  } vec_t;

  typedef struct {
    string         name;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [TW-1:0] sc;
    logic [TW-1:0] fc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  function automatic vec_t mk(
    input string name, input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm,
    input logic [4:0] exrd, input logic exrw, input logic exmr, input logic [4:0] memrd, input logic memrw,
    input logic br, input logic es, input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
    input int unsigned ds, input int unsigned df);
    vec_t v;
    v.name = name; v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm;
    v.exrd = exrd; v.exrw = exrw; v.exmr = exmr; v.memrd = memrd; v.memrw = memrw;
    v.br = br; v.es = es; v.ctl = ctl; v.fa = fa; v.fb = fb; v.ds = ds; v.df = df;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_Rn = v.rn; id_Rm = v.rm; id_usesRn = v.urn; id_usesRm = v.urm;
    ex_Rd = v.exrd; ex_RegWrite = v.exrw; ex_MemRead = v.exmr;
    mem_Rd = v.memrd; mem_RegWrite = v.memrw;
    branch_taken = v.br; ext_stall = v.es;
  endtask

  task automatic bump(input int unsigned ds, input int unsigned df);
`ifdef HAZARD_STATS_EN
    m_stall = (m_stall + ds > CMAX) ? CMAX : m_stall + ds;
    m_flush = (m_flush + df > CMAX) ? CMAX : m_flush + df;
`else
    m_stall = ds * 0;
    m_flush = df * 0;
`endif
  endtask

  task automatic step(input vec_t v);
    exp_t e, g;
    @(negedge clk);
    drive(v);
    #1;
    chk({v.name, " ctl"}, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, v.ctl});
    bump(v.ds, v.df);
    e.name = v.name; e.fa = v.fa; e.fb = v.fb; e.sc = TW'(m_stall); e.fc = TW'(m_flush);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({g.name, " fwdA"}, {30'd0, fwdA}, {30'd0, g.fa});
    chk({g.name, " fwdB"}, {30'd0, fwdB}, {30'd0, g.fb});
    chk({g.name, " stall_cnt"}, {28'd0, stall_cnt}, {28'd0, g.sc});
    chk({g.name, " flush_cnt"}, {28'd0, flush_cnt}, {28'd0, g.fc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    z = mk("idle", 0,0,0,0, 0,0,0, 0,0, 0,0, 4'b1100, 2'b00, 2'b00, 0, 0);
    //         name            rn rm urn urm exrd rw mr memrd rw br es ctl      fa     fb     ds df
    vecs.push_back(z);
    vecs.push_back(mk("ex_mem_fwd",   5, 6,1,1,  5,1,0,  6,1, 0,0, 4'b1100, 2'b01, 2'b10, 0, 0));
    vecs.push_back(mk("load_use_rn",  3, 0,1,0,  3,1,1,  0,0, 0,0, 4'b0001, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("ex_over_mem",  0, 7,0,1,  7,1,0,  7,1, 0,0, 4'b1100, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk("xzr",          0,31,0,1, 31,1,1, 31,1, 0,0, 4'b1100, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("uses_gated",   4, 4,0,0,  4,1,1,  4,1, 0,0, 4'b1100, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mem_fwd_rn",   9, 0,1,0,  9,0,0,  9,1, 0,0, 4'b1100, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk("branch_lu",    3, 0,1,0,  3,1,1,  0,0, 1,0, 4'b1111, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk("set_fwdA",     5, 0,1,0,  5,1,0,  0,0, 0,0, 4'b1100, 2'b01, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("freeze_br",  9, 0,1,0,  0,0,0,  9,1, 1,1, 4'b0000, 2'b01, 2'b00, 1, 0));
    vecs.push_back(mk("br_after_frz", 9, 0,1,0,  0,0,0,  9,1, 1,0, 4'b1111, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk("load_use_rm",  0,12,0,1, 12,1,1,  0,0, 0,0, 4'b0001, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("load_no_rw",   3, 0,1,0,  3,0,1,  0,0, 0,0, 4'b1100, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mem_fwd_pre",  9, 0,1,0,  0,0,0,  9,1, 0,0, 4'b1100, 2'b10, 2'b00, 0, 0));

    reset = 1'b0;
    drive(z);
    #1;
    chk("reset fwdA", {30'd0, fwdA}, 32'd0);
    chk("reset fwdB", {30'd0, fwdB}, 32'd0);
    chk("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset flush_cnt", {28'd0, flush_cnt}, 32'd0);
    chk("reset ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, 32'hC);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // asynchronous reset between edges with fwdA=10 and five stalls counted
    @(negedge clk);
    drive(mk("lu_in_reset", 3,0,1,0, 3,1,1, 0,0, 0,0, 4'b0001, 2'b00, 2'b00, 0, 0));
    #2 reset = 1'b0;
    #1;
    chk("async fwdA", {30'd0, fwdA}, 32'd0);
    chk("async fwdB", {30'd0, fwdB}, 32'd0);
    chk("async stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("async flush_cnt", {28'd0, flush_cnt}, 32'd0);
    chk("reset comb ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, 32'h1);
    @(posedge clk);
    #1;
    chk("held stall_cnt", {28'd0, stall_cnt}, 32'd0);
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    drive(z);
    reset = 1'b1;

    // saturation: more freeze cycles than the counter can hold
    for (int i = 0; i < 18; i++)
      step(mk("sat_freeze", 0,0,0,0, 0,0,0, 0,0, 0,1, 4'b0000, 2'b00, 2'b00, 1, 0));
    step(mk("sat_branch", 0,0,0,0, 0,0,0, 0,0, 1,0, 4'b1111, 2'b00, 2'b00, 0, 1));
    step(z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage LEGv8 CPU. The pipeline registers carry control and data forward; this block sends control back to them. It watches register indices and control bits in the ID, EX and MEM stages. It drives PC/IF-ID write enables and IF-ID/ID-EX bubble insertion, and produces EX-aligned operand forwarding selects.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state while 0
- id_Rn, id_Rm  in  5 each  source register indices of the instruction in ID
- id_usesRn, id_usesRm  in  1 each  ID instruction actually reads Rn / Rm
- ex_Rd  in  5  destination of the instruction in EX
- ex_RegWrite, ex_MemRead  in  1 each  EX instruction writes the register file / is a load
- mem_Rd  in  5  destination of the instruction in MEM
- mem_RegWrite  in  1  MEM instruction writes the register file
- branch_taken  in  1  taken branch resolved in EX this cycle
- ext_stall  in  1  data memory busy; freeze the whole pipeline
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_flush  out  1  ID/EX register loads all-zero control (bubble)
- fwdA, fwdB  out  2 each  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- stall_cnt, flush_cnt  out  CNT_W each  statistics counters (see Configuration)

## Operation
- Load-use condition (LU): ex_MemRead & ex_RegWrite & ex_Rd!=31 & ((id_usesRn & id_Rn==ex_Rd) | (id_usesRm & id_Rm==ex_Rd)).
- Priority: ext_stall > branch_taken > LU > run.
  - ext_stall=1: pc_write=0, ifid_write=0, both flushes 0. Forwarding registers hold.
  - branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. Forwarding registers load 00/00.
  - LU: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1. Forwarding registers load 00/00 (bubble).
  - Run: pc_write=1, ifid_write=1, both flushes 0.
- Forward select computation, done in ID for each operand X in {Rn, Rm}, gated by id_usesX:
  - If ex_RegWrite & ex_Rd!=31 & ex_Rd==X, the next value is 01 (producer will be in MEM when the consumer reaches EX).
  - Else if mem_RegWrite & mem_Rd!=31 & mem_Rd==X, the next value is 10.
  - Else the next value is 00.
  - In run state the computed value loads into fwdA (Rn) / fwdB (Rm).
- X31 (XZR) is never forwarded and never triggers LU.
- WB-to-ID hazards are resolved by the register file's write-before-read and are not handled here.
- LU self-clears: after one bubble the load has left EX. No state is needed for it beyond the forwarding registers.

## Timing
- pc_write, ifid_write, ifid_flush and idex_flush are combinational from the current-cycle inputs, with zero latency.
- fwdA/fwdB are registered with one-cycle latency. The value computed in ID in cycle N is on the outputs in cycle N+1, while that instruction is in EX.
- Reset (reset=0), asynchronous and immediate:
  - fwdA=00, fwdB=00, stall_cnt=0, flush_cnt=0.
  - Combinational outputs follow the inputs; with all inputs 0 they are pc_write=1, ifid_write=1, flushes 0.
- Reset release takes effect at the first rising edge with reset=1.
- Simultaneous events:
  - branch_taken with LU: the flush wins and no stall is inserted.
  - ext_stall with branch_taken: freeze wins. EX is frozen, so branch_taken stays asserted and is acted on in the first non-stalled cycle.
- Reset asserted mid-stall or mid-flush clears the forwarding registers and counters immediately. There is no pending state to recover.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cnt increments on every rising edge with LU (not overridden by branch_taken) or ext_stall.
  - flush_cnt increments on every non-frozen edge with branch_taken.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
- HAZARD_STATS_EN undefined: counter logic is not built; stall_cnt and flush_cnt are tied to 0. All other behaviour is identical.

## Test plan
- Load-use: ID Rn=3 (usesRn=1), EX LDUR Rd=3 (MemRead=1, RegWrite=1) -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; next edge fwdA=00; stall_cnt +1 when enabled.
- EX forward: ID ADD Rn=5, Rm=6, EX Rd=5 (RegWrite=1), MEM Rd=6 (RegWrite=1) -> next cycle fwdA=01, fwdB=10.
- Priority: ex_Rd=mem_Rd=7, both RegWrite=1, ID Rm=7 -> fwdB=01. Same with Rd=31 -> fwdB=00 and no stall.
- Branch with LU: branch_taken=1 plus LU condition -> ifid_flush=1, idex_flush=1, pc_write=1; fwdA/B=00 next cycle; flush_cnt +1.
- ext_stall held 3 cycles with fwdA=01 -> pc_write=0 all 3 cycles, fwdA stays 01, stall_cnt +3; branch_taken asserted during the stall produces a flush only in the first cycle after ext_stall drops.
- Reset mid-operation: with fwdA=10 and stall_cnt=5, pull reset low between clock edges -> fwdA=00 and stall_cnt=0 immediately, without waiting for a clock edge.
